adder_tree_rr_sched: RTL and testbench

Round-robin scheduler that shares one registered accumulate datapath between two requesters, each submitting jobs of `NUM_OPS` unsigned operands. It time-multiplexes what the parallel adder tree computes spatially. Each job is reduced serially, one operand per accepted handshake, and returned as a single widened sum tagged with its source. It sits between operand producers and the downstream sum consumer wherever a full parallel tree is too large.

---
 rtl/adder_tree_rr_sched.sv | 167 ++++++++++++++++
 tb/tb_adder_tree_rr_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_rr_sched.sv
// adder_tree_rr_sched: serial accumulate datapath shared by two requesters.
// Each requester submits jobs of NUM_OPS unsigned operands, which are summed
// one per handshake into an ADDER_WIDTH+LOG_OPS wide result tagged with its
// source. Requesters are arbitrated round-robin by default.
//
// Optional feature macro: ADDER_SCHED_FIXED_PRI_EN
//   defined   -> requester 0 always wins simultaneous requests (no rr pointer)
//   undefined -> round-robin arbitration
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req0_valid/req0_ready/req0_data   requester 0 operand handshake
//   req1_valid/req1_ready/req1_data   requester 1 operand handshake
//   sum_valid/sum_ready               result handshake
//   sum_data                          job sum (ADDER_WIDTH+LOG_OPS bits)
//   sum_src                           requester index that produced sum_data
module adder_tree_rr_sched #(
  parameter int unsigned ADDER_WIDTH = 48,
  parameter int unsigned NUM_OPS     = 8,
  parameter int unsigned LOG_OPS     = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req0_valid,
  output logic                           req0_ready,
  input  logic [ADDER_WIDTH-1:0]         req0_data,
  input  logic                           req1_valid,
  output logic                           req1_ready,
  input  logic [ADDER_WIDTH-1:0]         req1_data,
  output logic                           sum_valid,
  input  logic                           sum_ready,
  output logic [ADDER_WIDTH+LOG_OPS-1:0] sum_data,
  output logic                           sum_src
);

  localparam int unsigned SUM_W = ADDER_WIDTH + LOG_OPS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic [LOG_OPS-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic               req0_ready_q, req0_ready_d;
  logic               req1_ready_q, req1_ready_d;
  logic               sum_valid_q, sum_valid_d;
  logic [SUM_W-1:0]   sum_data_q, sum_data_d;
  logic               sum_src_q, sum_src_d;
`ifndef ADDER_SCHED_FIXED_PRI_EN
  logic               rr_q, rr_d;
`endif

  logic               hs;
  logic               pick;
  logic [SUM_W-1:0]   op_ext;
  logic [SUM_W-1:0]   acc_nxt;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    req0_ready_d = req0_ready_q;
    req1_ready_d = req1_ready_q;
    sum_valid_d  = sum_valid_q;
    sum_data_d   = sum_data_q;
    sum_src_d    = sum_src_q;
`ifndef ADDER_SCHED_FIXED_PRI_EN
    rr_d         = rr_q;
`endif

    op_ext  = gnt_q ? SUM_W'(req1_data) : SUM_W'(req0_data);
    hs      = gnt_q ? (req1_valid & req1_ready_q) : (req0_valid & req0_ready_q);
    // first operand of a job loads, later ones accumulate
    acc_nxt = (cnt_q == '0) ? op_ext : (acc_q + op_ext);

`ifdef ADDER_SCHED_FIXED_PRI_EN
    pick = ~req0_valid;
`else
    pick = (req0_valid & req1_valid) ? rr_q : req1_valid;
`endif

    unique case (state_q)
      IDLE: begin
        if (req0_valid | req1_valid) begin
          gnt_d        = pick;
          cnt_d        = '0;
          req0_ready_d = ~pick;
          req1_ready_d = pick;
          state_d      = ACCUM;
        end
      end
      ACCUM: begin
        if (hs) begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + LOG_OPS'(1);
          if (cnt_q == LOG_OPS'(NUM_OPS - 1)) begin
            req0_ready_d = 1'b0;
            req1_ready_d = 1'b0;
            sum_valid_d  = 1'b1;
            sum_data_d   = acc_nxt;
            sum_src_d    = gnt_q;
            state_d      = OUT;
          end
        end
      end
      OUT: begin
        if (sum_ready) begin
          sum_valid_d = 1'b0;
`ifndef ADDER_SCHED_FIXED_PRI_EN
          rr_d        = ~gnt_q;
`endif
          state_d     = IDLE;
        end
      end
      default: begin
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
        sum_valid_d  = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      sum_valid_q  <= 1'b0;
      sum_data_q   <= '0;
      sum_src_q    <= 1'b0;
`ifndef ADDER_SCHED_FIXED_PRI_EN
      rr_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      req0_ready_q <= req0_ready_d;
      req1_ready_q <= req1_ready_d;
      sum_valid_q  <= sum_valid_d;
      sum_data_q   <= sum_data_d;
      sum_src_q    <= sum_src_d;
`ifndef ADDER_SCHED_FIXED_PRI_EN
      rr_q         <= rr_d;
`endif
    end
  end

  assign req0_ready = req0_ready_q;
  assign req1_ready = req1_ready_q;
  assign sum_valid  = sum_valid_q;
  assign sum_data   = sum_data_q;
  assign sum_src    = sum_src_q;

endmodule

// File: tb/tb_adder_tree_rr_sched.sv
// Scoreboard bench for adder_tree_rr_sched: directed jobs push expected
// results; a negedge monitor compares every result handshake and checks
// hold stability, valid drop, ready exclusivity and grant-to-result latency.
module tb_adder_tree_rr_sched;

  localparam int unsigned AW = 48;
  localparam int unsigned NO = 8;
  localparam int unsigned LO = 3;
  localparam int unsigned SW = AW + LO;

  typedef struct packed {
    logic          src;
    logic [SW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [AW-1:0] req0_data;
  logic          req1_valid, req1_ready;
  logic [AW-1:0] req1_data;
  logic          sum_valid, sum_ready;
  logic [SW-1:0] sum_data;
  logic          sum_src;

  logic [AW-1:0] ops0 [NO];
  logic [AW-1:0] ops1 [NO];
  exp_t          exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_rise = 0;
  logic lat_chk     = 1'b0;
  logic chk_r1_idle = 1'b0;
  logic bp_arm      = 1'b0;

  adder_tree_rr_sched #(.ADDER_WIDTH(AW), .NUM_OPS(NO), .LOG_OPS(LO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_data   (sum_data),
    .sum_src    (sum_src)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d results outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic s, input logic [SW-1:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int r, input logic v, input logic [AW-1:0] d);
    if (r == 1) begin
      req1_valid = v;
      req1_data  = d;
    end else begin
      req0_valid = v;
      req0_data  = d;
    end
  endtask

  // Sends n operands from requester r; optionally drops valid for gap_len
  // cycles after gap_after operands. Leaves valid high on return.
  task automatic send_job(input int r, input int n, input int gap_after, input int gap_len);
    int   i;
    int   wait_c;
    logic acc;
    i = 0;
    wait_c = 0;
    while (i < n) begin
      drive(r, 1'b1, (r == 1) ? ops1[i] : ops0[i]);
      @(negedge clk);
      acc = (r == 1) ? req1_ready : req0_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        wait_c = 0;
        if (i == gap_after && gap_len > 0) begin
          drive(r, 1'b0, '0);
          repeat (gap_len) begin
            @(posedge clk);
            #1;
          end
        end
      end else begin
        wait_c++;
        if (wait_c > 400) begin
          n_checks++;
          n_fail++;
          $display("FAIL ready_timeout: requester %0d operand %0d never accepted", r, i);
          i = n;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still expected, got none", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req0_ready"}, 64'(req0_ready), 64'd0);
    chk({tag, "_req1_ready"}, 64'(req1_ready), 64'd0);
    chk({tag, "_sum_valid"},  64'(sum_valid),  64'd0);
    chk({tag, "_sum_data"},   64'(sum_data),   64'd0);
    chk({tag, "_sum_src"},    64'(sum_src),    64'd0);
  endtask

  // Backpressure: hold sum_ready low 4 cycles after the next sum_valid rise
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_arm && sum_valid) begin
      sum_ready = 1'b0;
      repeat (4) begin
        @(posedge clk);
        #1;
      end
      sum_ready = 1'b1;
      bp_arm    = 1'b0;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic          p_valid, p_ready, p_rdy, p_src;
    logic [SW-1:0] p_data;
    exp_t          e;
    p_valid = 1'b0; p_ready = 1'b0; p_rdy = 1'b0; p_src = 1'b0; p_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_valid = 1'b0; p_ready = 1'b0; p_rdy = 1'b0;
      end else begin
        chk("ready_exclusive", 64'(req0_ready & req1_ready), 64'd0);
        if (chk_r1_idle) chk("req1_ready_during_req0_job", 64'(req1_ready), 64'd0);
        if (p_valid && !p_ready) begin
          chk("hold_valid", 64'(sum_valid), 64'd1);
          chk("hold_data",  64'(sum_data),  64'(p_data));
          chk("hold_src",   64'(sum_src),   64'(p_src));
        end
        if (p_valid && p_ready) chk("valid_drop_after_accept", 64'(sum_valid), 64'd0);
        if ((req0_ready | req1_ready) && !p_rdy) rdy_rise = cyc;
        if (sum_valid && !p_valid && lat_chk)
          chk("ready_to_result_latency", 64'(cyc - rdy_rise), 64'(NO));
        if (sum_valid && sum_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_sum: got data 0x%0h src %0d, expected no result", sum_data, sum_src);
          end else begin
            e = exp_q.pop_front();
            chk("sum_data", 64'(sum_data), 64'(e.data));
            chk("sum_src",  64'(sum_src),  64'(e.src));
          end
        end
        p_valid = sum_valid;
        p_ready = sum_ready;
        p_data  = sum_data;
        p_src   = sum_src;
        p_rdy   = req0_ready | req1_ready;
      end
    end
  end

  // Stimulus
  initial begin
    int wc;
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0;
    sum_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Single job 1..8 from requester 0
    for (int i = 0; i < NO; i++) ops0[i] = AW'(i + 1);
    push(1'b0, SW'(36));
    lat_chk = 1'b1;
    send_job(0, NO, 0, 0);
    drive(0, 1'b0, '0);
    wait_drain();

    // Max operands from requester 1
    for (int i = 0; i < NO; i++) ops1[i] = 48'hFFFF_FFFF_FFFF;
    push(1'b1, 51'h7_FFFF_FFFF_FFF8);
    send_job(1, NO, 0, 0);
    drive(1, 1'b0, '0);
    wait_drain();

    // Stall after operand 3, result backpressure, req1 waiting meanwhile
    lat_chk = 1'b0;
    for (int i = 0; i < NO; i++) ops0[i] = AW'(10 * (i + 1));
    for (int i = 0; i < NO; i++) ops1[i] = AW'(3);
    push(1'b0, SW'(360));
    push(1'b1, SW'(24));
    bp_arm = 1'b1;
    fork
      begin
        send_job(0, NO, 3, 5);
        drive(0, 1'b0, '0);
        chk_r1_idle = 1'b0;
      end
      begin
        wc = 0;
        while (!req0_ready && wc < 20) begin
          @(posedge clk);
          #1;
          wc++;
        end
        chk("req0_granted", 64'(req0_ready), 64'd1);
        chk_r1_idle = 1'b1;
        send_job(1, NO, 0, 0);
        drive(1, 1'b0, '0);
      end
    join
    wait_drain();

    // Fairness from a fresh reset, both requesters continuously valid
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat_chk = 1'b1;
    for (int i = 0; i < NO; i++) begin
      ops0[i] = AW'(1);
      ops1[i] = AW'(1);
    end
`ifdef ADDER_SCHED_FIXED_PRI_EN
    for (int k = 0; k < 8; k++) push((k >= 4), SW'(8));
`else
    for (int k = 0; k < 8; k++) push(k[0], SW'(8));
`endif
    fork
      begin
        for (int k = 0; k < 4; k++) send_job(0, NO, 0, 0);
        drive(0, 1'b0, '0);
      end
      begin
        for (int k = 0; k < 4; k++) send_job(1, NO, 0, 0);
        drive(1, 1'b0, '0);
      end
    join
    wait_drain();

    // Reset after 4 of 8 operands; partial job must vanish
    for (int i = 0; i < NO; i++) ops0[i] = AW'(i + 1);
    send_job(0, 4, 0, 0);
    rst = 1'b1;
    drive(0, 1'b0, '0);
    @(posedge clk);
    #1;
    check_reset_outputs("midjob_rst");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < NO; i++) ops0[i] = AW'(2);
    push(1'b0, SW'(16));
    send_job(0, NO, 0, 0);
    drive(0, 1'b0, '0);
    wait_drain();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
